// File: rtl/cipher_pkg.sv
// Shared definitions for the LFSR message-decryption sequencer.
// Holds the candidate tap table, the sequencer state encoding and the plaintext offset.
// No logic; imported by decrypt_seq and lfsr7_step users.
package cipher_pkg;

   localparam int NUM_PTRN = 9;

   // Candidate tap patterns; entry k is selected by ptrn_idx == k.
   localparam logic [NUM_PTRN-1:0][6:0] LFSR_PTRN = {
      7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60
   };

   // Plaintext is stored as (char - SPACE_OFS), so a space decrypts to zero.
   localparam logic [7:0] SPACE_OFS = 8'h20;

   typedef enum logic [3:0] {
      IDLE,
      SEED_RD,
      SEED_EX,
      SRCH_RD,
      SRCH_EX,
      PICK,
      DEC_RD,
      DEC_EX,
      PAD,
      DONE
   } state_e;

endpackage

// File: rtl/decrypt_seq_lfsr7_step.sv
// 7-bit LFSR single step: shift left, feed back the parity of the tapped bits.
// Latency: purely combinational. Backpressure: none.
// Ports: state_i current state, ptrn_i tap mask, next_o next state.
module lfsr7_step (
   input  logic [6:0] state_i,
   input  logic [6:0] ptrn_i,
   output logic [6:0] next_o
);

   assign next_o = {state_i[5:0], ^(state_i & ptrn_i)};

endmodule

// File: rtl/decrypt_seq.sv
// Sequencer that decrypts an LFSR-encrypted message straight out of data memory.
// Latency: 2 cycles per byte read (issue/consume), 1 cycle per pad write; ack held in DONE.
// Backpressure: none on DM (one access per cycle); new run only launches on req low in IDLE.
// Ports: clk/init_n clock and async reset; req/ack run handshake; mem_* DM access;
//        ptrn_idx/no_match/err_cnt/out_len run status.
module decrypt_seq
   import cipher_pkg::*;
#(
   parameter int AW        = 8,
   parameter int IN_BASE   = 64,
   parameter int OUT_BASE  = 0,
   parameter int MSG_LEN   = 64,
   parameter int PRE_CHECK = 10
) (
   input  logic          clk,
   input  logic          init_n,
   input  logic          req,
   output logic          ack,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd_en,
   output logic          mem_wr_en,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata,
   output logic [3:0]    ptrn_idx,
   output logic          no_match,
   output logic [6:0]    err_cnt,
   output logic [6:0]    out_len
);

   localparam logic [AW-1:0] IN_A     = AW'(IN_BASE);
   localparam logic [AW-1:0] OUT_A    = AW'(OUT_BASE);
   localparam logic [6:0]    LAST_PRE = 7'(PRE_CHECK - 1);
   localparam logic [6:0]    LAST_MSG = 7'(MSG_LEN - 1);
   localparam logic [6:0]    MSG_LEN7 = 7'(MSG_LEN);

   state_e                   state_q, state_d;
   logic [6:0]               idx_q, idx_d;        // byte index, reused as pad address
   logic [6:0]               seed_q, seed_d;
   logic [NUM_PTRN-1:0][6:0] srch_q, srch_d, srch_nxt;
   logic [NUM_PTRN-1:0]      alive_q, alive_d;
   logic [6:0]               dec_q, dec_d, dec_nxt;
   logic [6:0]               sel_q, sel_d;        // chosen tap pattern
   logic                     skip_q, skip_d;      // still stripping leading spaces
   logic [3:0]               ptrn_idx_q, ptrn_idx_d;
   logic                     no_match_q, no_match_d;
   logic [6:0]               err_q, err_d;
   logic [6:0]               len_q, len_d;

   logic [6:0]               pt;
   logic                     par_ok;
   logic [3:0]               pick_idx;
   logic [6:0]               pick_ptrn;

   for (genvar k = 0; k < NUM_PTRN; k++) begin : g_srch
      lfsr7_step u_step (
         .state_i (srch_q[k]),
         .ptrn_i  (LFSR_PTRN[k]),
         .next_o  (srch_nxt[k])
      );
   end

   lfsr7_step u_dec_step (
      .state_i (dec_q),
      .ptrn_i  (sel_q),
      .next_o  (dec_nxt)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      seed_d     = seed_q;
      srch_d     = srch_q;
      alive_d    = alive_q;
      dec_d      = dec_q;
      sel_d      = sel_q;
      skip_d     = skip_q;
      ptrn_idx_d = ptrn_idx_q;
      no_match_d = no_match_q;
      err_d      = err_q;
      len_d      = len_q;
      mem_addr   = '0;
      mem_rd_en  = 1'b0;
      mem_wr_en  = 1'b0;
      mem_wdata  = '0;
      pt         = mem_rdata[6:0] ^ dec_q;
      par_ok     = ~^mem_rdata;

      // Lowest surviving candidate wins.
      pick_idx  = '0;
      pick_ptrn = LFSR_PTRN[0];
      for (int k = NUM_PTRN - 1; k >= 0; k--) begin
         if (alive_q[k]) begin
            pick_idx  = 4'(k);
            pick_ptrn = LFSR_PTRN[k];
         end
      end

      case (state_q)
         IDLE: begin
            if (!req) begin
               ptrn_idx_d = '0;
               no_match_d = 1'b0;
               err_d      = '0;
               len_d      = '0;
               state_d    = SEED_RD;
            end
         end
         SEED_RD: begin
            mem_addr  = IN_A;
            mem_rd_en = 1'b1;
            state_d   = SEED_EX;
         end
         SEED_EX: begin
            // Byte 0 is a space, so its ciphertext is the seed itself.
            seed_d = mem_rdata[6:0];
            for (int k = 0; k < NUM_PTRN; k++) srch_d[k] = mem_rdata[6:0];
            alive_d = '1;
            idx_d   = 7'd1;
            state_d = SRCH_RD;
         end
         SRCH_RD: begin
            mem_addr  = IN_A + AW'(idx_q);
            mem_rd_en = 1'b1;
            state_d   = SRCH_EX;
         end
         SRCH_EX: begin
            for (int k = 0; k < NUM_PTRN; k++) begin
               srch_d[k] = srch_nxt[k];
               if (srch_nxt[k] != mem_rdata[6:0]) alive_d[k] = 1'b0;
            end
            if (idx_q == LAST_PRE) begin
               state_d = PICK;
            end else begin
               idx_d   = idx_q + 7'd1;
               state_d = SRCH_RD;
            end
         end
         PICK: begin
            if (alive_q == '0) begin
               no_match_d = 1'b1;
               state_d    = DONE;
            end else begin
               ptrn_idx_d = pick_idx;
               sel_d      = pick_ptrn;
               dec_d      = seed_q;
               skip_d     = 1'b1;
               idx_d      = '0;
               state_d    = DEC_RD;
            end
         end
         DEC_RD: begin
            mem_addr  = IN_A + AW'(idx_q);
            mem_rd_en = 1'b1;
            state_d   = DEC_EX;
         end
         DEC_EX: begin
            // A parity-failed byte always ends space stripping, even if it decrypts to 0.
            if (!(skip_q && par_ok && pt == 7'd0)) begin
               skip_d    = 1'b0;
               mem_wr_en = 1'b1;
               mem_addr  = OUT_A + AW'(len_q);
               mem_wdata = {~par_ok, pt};
               len_d     = len_q + 7'd1;
               if (!par_ok) err_d = err_q + 7'd1;
            end
            dec_d = dec_nxt;
            if (idx_q == LAST_MSG) begin
               idx_d   = len_d;
               state_d = (len_d == MSG_LEN7) ? DONE : PAD;
            end else begin
               idx_d   = idx_q + 7'd1;
               state_d = DEC_RD;
            end
         end
         PAD: begin
            mem_wr_en = 1'b1;
            mem_addr  = OUT_A + AW'(idx_q);
            if (idx_q == LAST_MSG) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + 7'd1;
            end
         end
         DONE: begin
            if (req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         seed_q     <= '0;
         srch_q     <= '0;
         alive_q    <= '0;
         dec_q      <= '0;
         sel_q      <= '0;
         skip_q     <= 1'b0;
         ptrn_idx_q <= '0;
         no_match_q <= 1'b0;
         err_q      <= '0;
         len_q      <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         seed_q     <= seed_d;
         srch_q     <= srch_d;
         alive_q    <= alive_d;
         dec_q      <= dec_d;
         sel_q      <= sel_d;
         skip_q     <= skip_d;
         ptrn_idx_q <= ptrn_idx_d;
         no_match_q <= no_match_d;
         err_q      <= err_d;
         len_q      <= len_d;
      end
   end

   assign ack      = (state_q == DONE);
   assign ptrn_idx = ptrn_idx_q;
   assign no_match = no_match_q;
   assign err_cnt  = err_q;
   assign out_len  = len_q;

endmodule

// File: tb/tb_decrypt_seq.sv
// Directed bench for decrypt_seq with a behavioural data memory beside it.
// Latency: n/a. Backpressure: n/a.
// Ports: none; drives clk/init_n/req and models DM read/write timing.
module tb_decrypt_seq;

   logic       clk    = 1'b0;
   logic       init_n = 1'b0;
   logic       req    = 1'b1;
   logic       ack, mem_rd_en, mem_wr_en, no_match;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0] ptrn_idx;
   logic [6:0] err_cnt, out_len;

   logic       ld_en   = 1'b0;
   logic [7:0] ld_addr = 8'h00;
   logic [7:0] ld_dat  = 8'h00;

   logic [7:0] dm [256];
   logic [7:0] ct [64];
   logic [7:0] exp_img [64];
   int         wr_cnt = 0;
   int         total  = 0;
   int         bad    = 0;
   int         cyc, nwr;
   string      msg = "four score and seven years ago...";

   always #5 clk = ~clk;

   decrypt_seq dut (
      .clk       (clk),
      .init_n    (init_n),
      .req       (req),
      .ack       (ack),
      .mem_addr  (mem_addr),
      .mem_rd_en (mem_rd_en),
      .mem_wr_en (mem_wr_en),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .ptrn_idx  (ptrn_idx),
      .no_match  (no_match),
      .err_cnt   (err_cnt),
      .out_len   (out_len)
   );

   // Data memory: read data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= dm[mem_addr];
      if (mem_wr_en) begin
         dm[mem_addr] <= mem_wdata;
         wr_cnt       <= wr_cnt + 1;
      end
      if (ld_en) dm[ld_addr] <= ld_dat;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] lstep(input logic [6:0] s, input logic [6:0] p);
      return {s[5:0], ^(s & p)};
   endfunction

   // 31 leading spaces then the 33-character message, encrypted with (seed, taps).
   task automatic build(input logic [6:0] seed, input logic [6:0] p);
      logic [6:0] s, x;
      logic [7:0] c;
      s = seed;
      for (int i = 0; i < 64; i++) begin
         if (i < 31) begin
            x = 7'h00;
         end else begin
            c = msg[i-31];
            x = 7'(c - 8'h20);
         end
         x     = x ^ s;
         ct[i] = {^x, x};
         s     = lstep(s, p);
      end
   endtask

   // Expected output image: message text starting at out index 'first', zeros elsewhere.
   task automatic set_exp(input int first);
      logic [7:0] c;
      for (int k = 0; k < 64; k++) exp_img[k] = 8'h00;
      for (int j = 0; j < 33; j++) begin
         c = msg[j];
         exp_img[first+j] = c - 8'h20;
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_dat  = d;
      @(negedge clk);
      ld_en   = 1'b0;
   endtask

   task automatic fill_out();
      for (int i = 0; i < 64; i++) poke(8'(i), 8'hEE);
   endtask

   task automatic load();
      for (int i = 0; i < 64; i++) poke(8'(64 + i), ct[i]);
      fill_out();
   endtask

   task automatic run(input string tag, input int budget, output int c, output int w);
      int wr0;
      wr0 = wr_cnt;
      req = 1'b0;
      c   = 0;
      while (ack !== 1'b1 && c < budget) begin
         @(negedge clk);
         c++;
      end
      check({tag, "_ack"}, ack, 1);
      w   = wr_cnt - wr0;
      req = 1'b1;
      @(negedge clk);
      check({tag, "_ack_drop"}, ack, 0);
   endtask

   task automatic check_img(input string tag);
      for (int k = 0; k < 64; k++)
         check($sformatf("%s_dm%0d", tag, k), dm[k], exp_img[k]);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ack", ack, 0);
      check("rst_rd", mem_rd_en, 0);
      check("rst_wr", mem_wr_en, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_ptrn", ptrn_idx, 0);
      check("rst_nomatch", no_match, 0);
      check("rst_err", err_cnt, 0);
      check("rst_len", out_len, 0);
      init_n = 1'b1;
      @(negedge clk);

      // Clean message, taps 0x60, seed 0x01.
      build(7'h01, 7'h60);
      set_exp(0);
      load();
      run("t1", 300, cyc, nwr);
      check("t1_cycles_ok", cyc <= 214, 1);
      check("t1_ptrn", ptrn_idx, 0);
      check("t1_nomatch", no_match, 0);
      check("t1_len", out_len, 33);
      check("t1_err", err_cnt, 0);
      check("t1_writes", nwr, 64);
      check_img("t1");

      // Taps 0x7B (idx 8), seed 0x55, single bit flip in byte 41 (output slot 10).
      build(7'h55, 7'h7B);
      set_exp(0);
      ct[41]      = ct[41] ^ 8'h01;
      exp_img[10] = 8'h80 | (exp_img[10] ^ 8'h01);
      load();
      run("t2", 300, cyc, nwr);
      check("t2_ptrn", ptrn_idx, 8);
      check("t2_len", out_len, 33);
      check("t2_err", err_cnt, 1);
      check_img("t2");

      // Two bits flipped in byte 50: parity passes, wrong text, no error flag.
      build(7'h55, 7'h7B);
      set_exp(0);
      ct[50]      = ct[50] ^ 8'h03;
      exp_img[19] = exp_img[19] ^ 8'h03;
      load();
      run("t3", 300, cyc, nwr);
      check("t3_err", err_cnt, 0);
      check("t3_len", out_len, 33);
      check_img("t3");

      // Parity error on a leading space (byte 25) ends stripping; later spaces are written.
      build(7'h01, 7'h60);
      set_exp(6);
      ct[25]     = ct[25] ^ 8'h80;
      exp_img[0] = 8'h80;
      load();
      run("t4", 300, cyc, nwr);
      check("t4_len", out_len, 39);
      check("t4_err", err_cnt, 1);
      check("t4_writes", nwr, 64);
      check_img("t4");

      // No candidate fits the preamble.
      for (int i = 0; i < 64; i++) ct[i] = 8'h00;
      ct[0] = 8'h81;
      for (int i = 1; i < 10; i++) ct[i] = 8'hFF;
      load();
      run("t5", 60, cyc, nwr);
      check("t5_cycles_ok", cyc <= 22, 1);
      check("t5_nomatch", no_match, 1);
      check("t5_ptrn", ptrn_idx, 0);
      check("t5_writes", nwr, 0);
      check("t5_len", out_len, 0);
      check("t5_dm0", dm[0], 8'hEE);

      // All-zero ciphertext: everything stripped, whole region padded.
      for (int i = 0; i < 64; i++) ct[i] = 8'h00;
      for (int k = 0; k < 64; k++) exp_img[k] = 8'h00;
      load();
      run("t6", 300, cyc, nwr);
      check("t6_ptrn", ptrn_idx, 0);
      check("t6_nomatch", no_match, 0);
      check("t6_len", out_len, 0);
      check("t6_writes", nwr, 64);
      check_img("t6");

      // Reset 50 cycles into a run, then a full run with req still low.
      build(7'h55, 7'h7B);
      set_exp(0);
      ct[41]      = ct[41] ^ 8'h01;
      exp_img[10] = 8'h81;
      load();
      req = 1'b0;
      repeat (50) @(negedge clk);
      init_n = 1'b0;
      #1;
      check("t7_rst_ack", ack, 0);
      check("t7_rst_ptrn", ptrn_idx, 0);
      check("t7_rst_rd", mem_rd_en, 0);
      check("t7_rst_wr", mem_wr_en, 0);
      check("t7_rst_len", out_len, 0);
      @(negedge clk);
      init_n = 1'b1;
      run("t7", 300, cyc, nwr);
      check("t7_ptrn", ptrn_idx, 8);
      check("t7_err", err_cnt, 1);
      check("t7_len", out_len, 33);
      check_img("t7");

      // Back-to-back rerun on the same ciphertext: counters restart from zero.
      fill_out();
      run("t8", 300, cyc, nwr);
      check("t8_err", err_cnt, 1);
      check("t8_len", out_len, 33);
      check("t8_writes", nwr, 64);
      check_img("t8");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
